adc_mic_responder: RTL

- Synthesizable device-side end of the badge's 3-wire serial mic-ADC link (adc_mic_cs, adc_mic_clk, adc_mic_sd); it plays the role of the ADC itself.
- It accepts parallel samples from a stream source (tone generator, capture replay or BRAM player), frames each one as an ADCS7476-style word, and shifts it onto sd under control of the master's cs/clk.
- It runs on the fast system clock and oversamples the master's cs/clk. It lets the waterfall front end be exercised on hardware loopback and in simulation without a behavioural model.

---
 rtl/adc_mic_responder_if.sv | 25 ++
 rtl/adc_mic_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/adc_mic_responder_if.sv
// Bundle of the sample-stream handshake, the 3-wire mic-ADC link and the frame status
// strobes between a stream/master side and the ADC-emulating responder.
interface adc_mic_responder_if #(
  parameter int DATA_W = 12
);
  logic              adc_cs;
  logic              adc_clk;
  logic              adc_sd;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              busy;
  logic              frame_done;
  logic              underrun;

  modport master (
    output adc_cs, adc_clk, in_data, in_valid,
    input  adc_sd, in_ready, busy, frame_done, underrun
  );

  modport slave (
    input  adc_cs, adc_clk, in_data, in_valid,
    output adc_sd, in_ready, busy, frame_done, underrun
  );
endinterface

// File: rtl/adc_mic_responder.sv
// Device-side end of the 3-wire mic-ADC link: frames stream samples as ADCS7476-style
// words and shifts them onto sd under the master's oversampled cs/clk.
module adc_mic_responder #(
  parameter int                DATA_W       = 12,
  parameter int                LEAD_BITS    = 4,
  parameter logic [DATA_W-1:0] RESET_SAMPLE = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  adc_mic_responder_if.slave   link
);

  localparam int FRAME_BITS = LEAD_BITS + DATA_W;
  localparam int CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_t;

  logic [2:0]            csSync_q;
  logic [2:0]            sclkSync_q;
  state_t                state_q;
  logic                  holdFull_q;
  logic [DATA_W-1:0]     holdData_q;
  logic [DATA_W-1:0]     lastSample_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [CNT_W-1:0]      bitCnt_q;
  logic                  sd_q;
  logic                  frameDone_q;
  logic                  underrun_q;

  logic                  csFall;
  logic                  csRise;
  logic                  sclkFall;
  logic                  startFrame;
  logic                  starved;
  logic [DATA_W-1:0]     startSample_d;
  logic [FRAME_BITS-1:0] frameWord_d;

  // Bits [1:0] are the synchroniser, bit [2] is the delayed copy used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csSync_q   <= '0;
      sclkSync_q <= '0;
    end else begin
      csSync_q   <= {csSync_q[1:0], link.adc_cs};
      sclkSync_q <= {sclkSync_q[1:0], link.adc_clk};
    end
  end

  assign csFall   =  csSync_q[2]   & ~csSync_q[1];
  assign csRise   = ~csSync_q[2]   &  csSync_q[1];
  assign sclkFall =  sclkSync_q[2] & ~sclkSync_q[1];

  assign startFrame = (state_q == IDLE) && csFall;

  always_comb begin
    startSample_d = lastSample_q;
    starved       = 1'b0;
    if (holdFull_q) begin
      startSample_d = holdData_q;
    end else if (link.in_valid) begin
      startSample_d = link.in_data;
    end else begin
      starved = 1'b1;
    end
    frameWord_d = FRAME_BITS'(startSample_d);
  end

  // The last data bit stays on sd after entering TAIL so the master can still sample it on
  // its final rising edge; the next sclk fall or cs rise returns sd to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      holdFull_q   <= 1'b0;
      holdData_q   <= '0;
      lastSample_q <= RESET_SAMPLE;
      shift_q      <= '0;
      bitCnt_q     <= '0;
      sd_q         <= 1'b0;
      frameDone_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      underrun_q  <= 1'b0;

      if (startFrame && holdFull_q) begin
        holdFull_q <= 1'b0;
      end else if (!startFrame && link.in_valid && !holdFull_q) begin
        holdFull_q <= 1'b1;
        holdData_q <= link.in_data;
      end

      if (csRise) begin
        state_q <= IDLE;
        sd_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            sd_q <= 1'b0;
            if (csFall) begin
              state_q      <= SHIFT;
              shift_q      <= frameWord_d;
              bitCnt_q     <= '0;
              sd_q         <= frameWord_d[FRAME_BITS-1];
              lastSample_q <= startSample_d;
              underrun_q   <= starved;
            end
          end
          SHIFT: begin
            if (sclkFall) begin
              shift_q  <= shift_q << 1;
              bitCnt_q <= bitCnt_q + CNT_W'(1);
              sd_q     <= shift_q[FRAME_BITS-2];
              if (bitCnt_q == CNT_W'(FRAME_BITS - 2)) begin
                frameDone_q <= 1'b1;
                state_q     <= TAIL;
              end
            end
          end
          TAIL: begin
            if (sclkFall) begin
              sd_q <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            sd_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign link.adc_sd     = sd_q;
  assign link.in_ready   = !holdFull_q;
  assign link.busy       = (state_q != IDLE);
  assign link.frame_done = frameDone_q;
  assign link.underrun   = underrun_q;

endmodule
